// File: rtl/imem_dump_pkg.sv
// Shared definitions for the instruction-memory readback engine.
package imem_dump_pkg;

    // Engine states; CSUM is only reachable when IMEM_DUMP_CSUM_EN is defined.
    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SEND,
        CSUM,
        DONE
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE_IDX  = 2'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/imem_dump_if.sv
// Byte stream channel from the readback engine to its sink (debug host, trace FIFO).
interface imem_dump_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/imem_dump_ser.sv
// imem_dump_ser: 32-bit to 8-bit little-endian serializer with valid/ready output.
// A load starts a new word at byte start_idx; start_idx=LAST_BYTE_IDX sends a single byte.
module imem_dump_ser
    import imem_dump_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] word,
    input  logic [1:0]  start_idx,
    imem_dump_if.master tx,
    output logic        last_byte_accepted
);

    logic [31:0] shift;
    logic [1:0]  byte_idx;
    logic        valid;
    logic        accept;

    assign accept             = valid & tx.tx_ready;
    assign last_byte_accepted = accept & (byte_idx == LAST_BYTE_IDX);
    assign tx.tx_valid        = valid;
    assign tx.tx_data         = shift[7:0];

    // Shift register and byte counter; valid holds until the final byte of the word is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            shift    <= '0;
            byte_idx <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            shift    <= word;
            byte_idx <= start_idx;
        end else if (accept) begin
            shift <= shift >> 8;
            if (byte_idx == LAST_BYTE_IDX) begin
                valid <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

endmodule

// File: rtl/imem_dump.sv
// imem_dump: reads num_words words of instruction memory starting at base_addr through
// the test port and streams them out as bytes, least significant byte first.
// Define IMEM_DUMP_CSUM_EN to append an 8-bit additive checksum byte after the data.
module imem_dump
    import imem_dump_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_data,
    imem_dump_if.master       tx,
    output logic              busy,
    output logic              done
);

    state_t           state;
    logic [CNT_W-1:0] words_left;
    logic             ser_load;
    logic [31:0]      ser_word;
    logic [1:0]       ser_start_idx;
    logic             last_byte_accepted;
    logic [ADDR_W-1:0] next_addr;

    assign next_addr = (mem_addr == ADDR_W'(DEPTH - 1)) ? '0 : mem_addr + ADDR_W'(1);

`ifdef IMEM_DUMP_CSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_next;
    logic       enter_csum;

    // The sum including the byte being accepted this cycle, so the checksum word can be
    // loaded on the same edge as the last data byte and follow it without a gap.
    assign csum_next  = csum + tx.tx_data;
    assign enter_csum = (state == SEND) && last_byte_accepted && (words_left == CNT_W'(1));
`endif

    // Serializer load: a fresh memory word at the end of FETCH, or the checksum byte.
    always_comb begin
        ser_load      = (state == FETCH);
        ser_word      = mem_data;
        ser_start_idx = 2'd0;
`ifdef IMEM_DUMP_CSUM_EN
        if (enter_csum) begin
            ser_load      = 1'b1;
            ser_word      = {24'h0, csum_next};
            ser_start_idx = LAST_BYTE_IDX;
        end else if ((state == IDLE) && start && (num_words == '0)) begin
            ser_load      = 1'b1;
            ser_word      = 32'h0;
            ser_start_idx = LAST_BYTE_IDX;
        end
`endif
    end

    imem_dump_ser u_ser (
        .clk                (clk),
        .reset              (reset),
        .load               (ser_load),
        .word               (ser_word),
        .start_idx          (ser_start_idx),
        .tx                 (tx),
        .last_byte_accepted (last_byte_accepted)
    );

    // Dump sequencer: address and word counters, busy/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_addr   <= '0;
            words_left <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef IMEM_DUMP_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr   <= base_addr % ADDR_W'(DEPTH);
                        words_left <= num_words;
                        busy       <= 1'b1;
`ifdef IMEM_DUMP_CSUM_EN
                        csum       <= '0;
                        state      <= (num_words == '0) ? CSUM : FETCH;
`else
                        state      <= (num_words == '0) ? DONE : FETCH;
`endif
                    end
                end
                FETCH: begin
                    state <= SEND;
                end
                SEND: begin
`ifdef IMEM_DUMP_CSUM_EN
                    if (tx.tx_valid && tx.tx_ready) begin
                        csum <= csum_next;
                    end
`endif
                    if (last_byte_accepted) begin
                        words_left <= words_left - CNT_W'(1);
                        if (words_left == CNT_W'(1)) begin
`ifdef IMEM_DUMP_CSUM_EN
                            state <= CSUM;
`else
                            state <= DONE;
`endif
                        end else begin
                            mem_addr <= next_addr;
                            state    <= FETCH;
                        end
                    end
                end
`ifdef IMEM_DUMP_CSUM_EN
                CSUM: begin
                    if (last_byte_accepted) begin
                        state <= DONE;
                    end
                end
`endif
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
